// File: rtl/rx_frame_timer.sv
// Bit-timing engine for the serial receive path: after a rising enable it strobes every data,
// parity and stop bit of one frame, then pulses packet_done and holds until enable drops.
module rx_frame_timer #(
  parameter int unsigned PERIOD_BITS   = 14,
  parameter int unsigned SIZE_BITS     = 4,
  parameter bit          CENTER_SAMPLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable_timer,
  input  logic [PERIOD_BITS-1:0] bit_period,
  input  logic [SIZE_BITS-1:0]   data_size,
  input  logic                   parity_en,
  input  logic [1:0]             stop_bits,
  output logic                   shift_enable,
  output logic                   parity_strobe,
  output logic                   stop_strobe,
  output logic                   packet_done,
  output logic                   busy,
  output logic [SIZE_BITS-1:0]   bit_index
);

  localparam int unsigned BW = SIZE_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } state_t;

  state_t                 state;
  logic [PERIOD_BITS-1:0] per_q;
  logic [PERIOD_BITS-1:0] cnt;
  logic [SIZE_BITS-1:0]   size_q;
  logic                   par_q;
  logic [1:0]             stop_q;
  logic [BW-1:0]          bit_cnt;
  logic                   en_q;

  logic [PERIOD_BITS-1:0] per_in;
  logic [SIZE_BITS-1:0]   size_in;
  logic [1:0]             stop_in;
  logic [PERIOD_BITS-1:0] start_last;
  logic [PERIOD_BITS-1:0] per_last;
  logic [PERIOD_BITS-1:0] per_pre;
  logic [BW-1:0]          data_last;
  logic [BW-1:0]          stop_last;

  always_comb begin
    per_in  = (bit_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : bit_period;
    size_in = (data_size == '0) ? SIZE_BITS'(1) : data_size;
    stop_in = stop_bits;
    if (stop_bits == 2'd0) begin
      stop_in = 2'd1;
    end else if (stop_bits == 2'd3) begin
      stop_in = 2'd2;
    end
    per_last   = per_q - PERIOD_BITS'(1);
    per_pre    = per_q - PERIOD_BITS'(2);
    start_last = (CENTER_SAMPLE ? (per_q >> 1) : per_q) - PERIOD_BITS'(1);
    data_last  = BW'(size_q) - BW'(1);
    stop_last  = BW'(stop_q) - BW'(1);
  end

  // Strobes are registered one cycle ahead (cnt == P-2) so they appear in the
  // last cycle of each bit period, i.e. while cnt == P-1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      per_q         <= '0;
      size_q        <= '0;
      par_q         <= 1'b0;
      stop_q        <= '0;
      en_q          <= 1'b1;   // an enable level held across reset is not a start
      shift_enable  <= 1'b0;
      parity_strobe <= 1'b0;
      stop_strobe   <= 1'b0;
      packet_done   <= 1'b0;
      busy          <= 1'b0;
      bit_index     <= '0;
    end else begin
      en_q          <= enable_timer;
      shift_enable  <= 1'b0;
      parity_strobe <= 1'b0;
      stop_strobe   <= 1'b0;
      packet_done   <= 1'b0;
      bit_index     <= '0;
      if (state != IDLE && !enable_timer) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enable_timer && !en_q) begin
              per_q   <= per_in;
              size_q  <= size_in;
              par_q   <= parity_en;
              stop_q  <= stop_in;
              cnt     <= '0;
              bit_cnt <= '0;
              busy    <= 1'b1;
              state   <= START;
            end
          end
          START: begin
            if (cnt == start_last) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + PERIOD_BITS'(1);
            end
          end
          DATA, PARITY, STOP: begin
            if (cnt == per_pre) begin
              if (state == DATA) begin
                shift_enable <= 1'b1;
                bit_index    <= bit_cnt[SIZE_BITS-1:0];
              end else if (state == PARITY) begin
                parity_strobe <= 1'b1;
              end else begin
                stop_strobe <= 1'b1;
                packet_done <= (bit_cnt == stop_last);
              end
            end
            if (cnt == per_last) begin
              cnt <= '0;
              if (state == DATA) begin
                if (bit_cnt == data_last) begin
                  bit_cnt <= '0;
                  state   <= par_q ? PARITY : STOP;
                end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                end
              end else if (state == PARITY) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else if (bit_cnt == stop_last) begin
                bit_cnt <= '0;
                busy    <= 1'b0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              cnt <= cnt + PERIOD_BITS'(1);
            end
          end
          HOLD: begin
            state <= HOLD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_timer.sv
// Bench for rx_frame_timer: centre- and end-sampling instances share stimulus and are checked
// every cycle against a frame-schedule model computed from bit-position arithmetic.
module tb_rx_frame_timer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        enable_timer;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        parity_en;
  logic [1:0]  stop_bits;

  logic       c_shift, c_par, c_stop, c_done, c_busy;
  logic [3:0] c_idx;
  logic       e_shift, e_par, e_stop, e_done, e_busy;
  logic [3:0] e_idx;
  logic [8:0] out_c, out_e;
  logic [8:0] exp_c, exp_e;

  int n_checks = 0;
  int n_errors = 0;

  // model: started flag, cycles since start edge, sanitised latched config
  int m_mode = 0;
  int m_n = 0;
  int mp = 2, md = 1, mpar = 0, mt = 1;
  bit m_prev_en = 1'b1;

  always #5 clk = ~clk;

  assign out_c = {c_shift, c_par, c_stop, c_done, c_busy, c_idx};
  assign out_e = {e_shift, e_par, e_stop, e_done, e_busy, e_idx};

  rx_frame_timer #(.PERIOD_BITS(14), .SIZE_BITS(4), .CENTER_SAMPLE(1'b1)) dut_c (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .bit_period(bit_period),
    .data_size(data_size), .parity_en(parity_en), .stop_bits(stop_bits),
    .shift_enable(c_shift), .parity_strobe(c_par), .stop_strobe(c_stop),
    .packet_done(c_done), .busy(c_busy), .bit_index(c_idx));

  rx_frame_timer #(.PERIOD_BITS(14), .SIZE_BITS(4), .CENTER_SAMPLE(1'b0)) dut_e (
    .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .bit_period(bit_period),
    .data_size(data_size), .parity_en(parity_en), .stop_bits(stop_bits),
    .shift_enable(e_shift), .parity_strobe(e_par), .stop_strobe(e_stop),
    .packet_done(e_done), .busy(e_busy), .bit_index(e_idx));

  // {shift, parity, stop, done, busy, idx[3:0]} expected m_n cycles after the start edge
  function automatic logic [8:0] model_out(input bit center);
    int s, t, b, last;
    logic [8:0] v;
    v = '0;
    if (m_mode == 1) begin
      s    = center ? (mp / 2) : mp;
      last = s + (md + mpar + mt) * mp - 1;
      if (m_n <= last) begin
        v[4] = 1'b1;
        t = m_n - s + 1;
        if (t > 0 && (t % mp) == 0) begin
          b = t / mp - 1;
          if (b < md) begin
            v[8]   = 1'b1;
            v[3:0] = 4'(b);
          end else if (mpar == 1 && b == md) begin
            v[7] = 1'b1;
          end else begin
            v[6] = 1'b1;
            v[5] = (b == md + mpar + mt - 1);
          end
        end
      end
    end
    return v;
  endfunction

  task automatic set_cfg(input int p, input int d, input int par, input int t);
    bit_period = 14'(p);
    data_size  = 4'(d);
    parity_en  = (par != 0);
    stop_bits  = 2'(t);
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_n       = 0;
    m_prev_en = 1'b1;
    exp_c     = '0;
    exp_e     = '0;
  endtask

  task automatic step();
    bit en, par;
    int p, d, tt;
    en  = enable_timer;
    p   = int'(bit_period);
    d   = int'(data_size);
    par = parity_en;
    tt  = int'(stop_bits);
    @(posedge clk);
    if (m_mode == 0) begin
      if (en && !m_prev_en) begin
        m_mode = 1;
        m_n    = 0;
        mp     = (p < 2) ? 2 : p;
        md     = (d == 0) ? 1 : d;
        mpar   = par ? 1 : 0;
        mt     = (tt == 0) ? 1 : ((tt == 3) ? 2 : tt);
      end
    end else if (!en) begin
      m_mode = 0;
    end else begin
      m_n++;
    end
    m_prev_en = en;
    #1;
    exp_c = model_out(1'b1);
    exp_e = model_out(1'b0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    enable_timer = 1'b0;
    set_cfg(10, 8, 0, 1);
    model_reset();
    #3;
    n_checks++;
    if (out_c !== 9'd0) begin n_errors++; $display("FAIL reset_c got=%b exp=%b", out_c, 9'd0); end
    n_checks++;
    if (out_e !== 9'd0) begin n_errors++; $display("FAIL reset_e got=%b exp=%b", out_e, 9'd0); end
    enable_timer = 1'b1;
    #4 n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL held_after_reset_c i=%0d got=%b exp=%b", i, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL held_after_reset_e i=%0d got=%b exp=%b", i, out_e, exp_e); end
    end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_basic();
    int done_at = -1;
    int shifts = 0;
    set_cfg(10, 8, 0, 1);
    enable_timer = 1'b1;
    for (int i = 0; i < 110; i++) begin
      step();
      if (c_done) done_at = m_n;
      if (c_shift) shifts++;
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL basic_c n=%0d got=%b exp=%b", m_n, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL basic_e n=%0d got=%b exp=%b", m_n, out_e, exp_e); end
    end
    n_checks++;
    if (done_at !== 94) begin n_errors++; $display("FAIL basic_done_cycle got=%0d exp=94", done_at); end
    n_checks++;
    if (shifts !== 8) begin n_errors++; $display("FAIL basic_shift_count got=%0d exp=8", shifts); end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_parity();
    int done_at = -1;
    int dones = 0;
    set_cfg(4, 5, 1, 2);
    enable_timer = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (c_done) begin done_at = m_n; dones++; end
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL parity_c n=%0d got=%b exp=%b", m_n, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL parity_e n=%0d got=%b exp=%b", m_n, out_e, exp_e); end
    end
    n_checks++;
    if (done_at !== 33 || dones !== 1) begin
      n_errors++; $display("FAIL parity_done got=%0d/%0d exp=33/1", done_at, dones);
    end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_abort();
    set_cfg(10, 8, 0, 1);
    enable_timer = 1'b1;
    step();
    for (int i = 1; i <= 70; i++) begin
      enable_timer = (i < 30 || i >= 40);
      step();
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL abort_c edge=%0d got=%b exp=%b", i, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL abort_e edge=%0d got=%b exp=%b", i, out_e, exp_e); end
      if (i == 30) begin
        n_checks++;
        if (out_c !== 9'd0) begin n_errors++; $display("FAIL abort_clear got=%b exp=%b", out_c, 9'd0); end
      end
      if (i == 54) begin
        n_checks++;
        if (out_c !== 9'b1_0001_0000) begin n_errors++; $display("FAIL abort_restart got=%b exp=%b", out_c, 9'b1_0001_0000); end
      end
    end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_sanitize();
    int done_at = -1;
    int stops = 0;
    set_cfg(1, 0, 0, 0);
    enable_timer = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (c_done) done_at = m_n;
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL sanit_c n=%0d got=%b exp=%b", m_n, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL sanit_e n=%0d got=%b exp=%b", m_n, out_e, exp_e); end
    end
    n_checks++;
    if (done_at !== 4) begin n_errors++; $display("FAIL sanit_done got=%0d exp=4", done_at); end
    enable_timer = 1'b0;
    step();
    step();
    set_cfg(1, 0, 0, 3);
    enable_timer = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (c_stop) stops++;
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL sanit3_c n=%0d got=%b exp=%b", m_n, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL sanit3_e n=%0d got=%b exp=%b", m_n, out_e, exp_e); end
    end
    n_checks++;
    if (stops !== 2) begin n_errors++; $display("FAIL sanit_stop_count got=%0d exp=2", stops); end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_config_reset();
    set_cfg(10, 8, 0, 1);
    enable_timer = 1'b1;
    step();
    for (int i = 1; i <= 50; i++) begin
      if (i == 20) set_cfg(3, 2, 1, 3);
      step();
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL cfgchg_c edge=%0d got=%b exp=%b", i, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL cfgchg_e edge=%0d got=%b exp=%b", i, out_e, exp_e); end
    end
    n_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_c !== 9'd0) begin n_errors++; $display("FAIL midreset_c got=%b exp=%b", out_c, 9'd0); end
    n_checks++;
    if (out_e !== 9'd0) begin n_errors++; $display("FAIL midreset_e got=%b exp=%b", out_e, 9'd0); end
    #2 n_rst = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 15) enable_timer = 1'b0;
      if (i == 16) enable_timer = 1'b1;
      step();
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL postreset_c i=%0d got=%b exp=%b", i, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL postreset_e i=%0d got=%b exp=%b", i, out_e, exp_e); end
    end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_end_sample();
    int done_at = -1;
    int first_shift = -1;
    set_cfg(6, 2, 0, 1);
    enable_timer = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (e_done) done_at = m_n;
      if (e_shift && first_shift < 0) first_shift = m_n;
      n_checks++;
      if (out_c !== exp_c) begin n_errors++; $display("FAIL endsamp_c n=%0d got=%b exp=%b", m_n, out_c, exp_c); end
      n_checks++;
      if (out_e !== exp_e) begin n_errors++; $display("FAIL endsamp_e n=%0d got=%b exp=%b", m_n, out_e, exp_e); end
    end
    n_checks++;
    if (done_at !== 23 || first_shift !== 11) begin
      n_errors++; $display("FAIL endsamp_timing got=%0d/%0d exp=11/23", first_shift, done_at);
    end
    enable_timer = 1'b0;
    step();
    step();
  endtask

  task automatic test_random();
    int p, d, par, t, sp, flen, run, gap;
    for (int f = 0; f < 25; f++) begin
      p   = $urandom_range(0, 9);
      d   = $urandom_range(0, 15);
      par = $urandom_range(0, 1);
      t   = $urandom_range(0, 3);
      set_cfg(p, d, par, t);
      sp   = (p < 2) ? 2 : p;
      flen = sp + (((d == 0) ? 1 : d) + par + ((t == 0) ? 1 : ((t == 3) ? 2 : t))) * sp;
      run  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, flen) : flen + $urandom_range(1, 5);
      enable_timer = 1'b1;
      for (int i = 0; i < run; i++) begin
        if (i > 0 && $urandom_range(0, 1) == 1)
          set_cfg($urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3));
        step();
        n_checks++;
        if (out_c !== exp_c) begin n_errors++; $display("FAIL rand_c f=%0d n=%0d got=%b exp=%b", f, m_n, out_c, exp_c); end
        n_checks++;
        if (out_e !== exp_e) begin n_errors++; $display("FAIL rand_e f=%0d n=%0d got=%b exp=%b", f, m_n, out_e, exp_e); end
      end
      enable_timer = 1'b0;
      gap = $urandom_range(1, 3);
      for (int i = 0; i < gap; i++) begin
        step();
        n_checks++;
        if (out_c !== exp_c) begin n_errors++; $display("FAIL rand_gap_c f=%0d got=%b exp=%b", f, out_c, exp_c); end
        n_checks++;
        if (out_e !== exp_e) begin n_errors++; $display("FAIL rand_gap_e f=%0d got=%b exp=%b", f, out_e, exp_e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_abort();
    test_sanitize();
    test_config_reset();
    test_end_sample();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
